// File: rtl/sobel_line_window_reader.sv
// Four rotating line buffers feeding 3-pixel vertical columns to the Sobel kernel.
// The write side fills the newest line while the read side consumes the oldest three.
module sobel_line_window_reader #(
  parameter int DATA_W    = 8,
  parameter int IMG_WIDTH = 10,
  parameter int COL_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] top_o,
  output logic [DATA_W-1:0] mid_o,
  output logic [DATA_W-1:0] bot_o,
  output logic              valid_o,
  output logic              window_ready_o,
  output logic              line_done_o,
  output logic              row_done_o,
  output logic              overflow_o
);

  typedef struct packed {
    logic [DATA_W-1:0] top;
    logic [DATA_W-1:0] mid;
    logic [DATA_W-1:0] bot;
  } col_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  logic [DATA_W-1:0] mem [4][IMG_WIDTH];

  logic [COL_W-1:0] w_col, r_col;
  logic [1:0]       w_sel, r_sel;
  logic [2:0]       filled;
  col_t             col_q;

  logic wr_acc, wr_last, rd_acc, rd_last;

  assign wr_acc  = we_i && (filled < 3'd4);
  assign wr_last = wr_acc && (w_col == LAST_COL);
  assign rd_acc  = rd_en_i && (filled >= 3'd3);
  assign rd_last = rd_acc && (r_col == LAST_COL);

  // RAM contents survive reset; only pointers and flags clear.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_sel][w_col] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_col          <= '0;
      w_sel          <= '0;
      r_col          <= '0;
      r_sel          <= '0;
      filled         <= '0;
      col_q          <= '0;
      valid_o        <= 1'b0;
      window_ready_o <= 1'b0;
      line_done_o    <= 1'b0;
      row_done_o     <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      if (wr_acc) begin
        w_col <= wr_last ? '0 : w_col + 1'b1;
        if (wr_last) w_sel <= w_sel + 2'd1;
      end
      if (rd_acc) begin
        r_col     <= rd_last ? '0 : r_col + 1'b1;
        if (rd_last) r_sel <= r_sel + 2'd1;
        // 2-bit selects wrap modulo 4 on their own
        col_q.top <= mem[r_sel][r_col];
        col_q.mid <= mem[r_sel + 2'd1][r_col];
        col_q.bot <= mem[r_sel + 2'd2][r_col];
      end
      // Simultaneous line completion on both sides leaves occupancy unchanged.
      case ({wr_last, rd_last})
        2'b10:   filled <= filled + 3'd1;
        2'b01:   filled <= filled - 3'd1;
        default: filled <= filled;
      endcase
      valid_o        <= rd_acc;
      row_done_o     <= rd_last;
      line_done_o    <= wr_last;
      window_ready_o <= (filled >= 3'd3);
      if (we_i && (filled == 3'd4)) overflow_o <= 1'b1;
    end
  end

  assign top_o = col_q.top;
  assign mid_o = col_q.mid;
  assign bot_o = col_q.bot;

endmodule

// File: doc/sobel_line_window_reader.md
Name: sobel_line_window_reader

Overview:
- Read side of the Sobel line-buffering path.
- Accepts the raster pixel stream, one pixel per `we_i` cycle, into four rotating line buffers.
- Once three complete lines are held, streams 3-pixel vertical columns (top/mid/bot) to the Sobel kernel on request.
- Frees the oldest line after each full line read. Writing continues into the fourth buffer while reading proceeds.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_WIDTH, 10, pixels per line.
- COL_W, 4, column counter width; must satisfy 2^COL_W >= IMG_WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- we_i  in  1  write strobe; `data_i` is captured when high.
- data_i  in  DATA_W  incoming pixel.
- rd_en_i  in  1  read request for the next column.
- top_o  out  DATA_W  pixel from oldest held line.
- mid_o  out  DATA_W  pixel from middle line.
- bot_o  out  DATA_W  pixel from newest complete line.
- valid_o  out  1  `top_o`/`mid_o`/`bot_o` are valid this cycle.
- window_ready_o  out  1  three or more complete lines are held.
- line_done_o  out  1  one-cycle pulse when a written line completes.
- row_done_o  out  1  one-cycle pulse alongside the last column of a line read.
- overflow_o  out  1  sticky; a write was attempted while all four buffers were full.

Behaviour:
- Reset (`rst`=0 at a clock edge): all counters, pointers and flags clear. `top_o`/`mid_o`/`bot_o`=0, `valid_o`=0, `window_ready_o`=0, `line_done_o`=0, `row_done_o`=0, `overflow_o`=0. Buffer RAM contents are not cleared.
- Reset mid-operation discards all held lines; the next accepted write is column 0 of buffer 0.
- Write side:
  - `w_col` counts 0..IMG_WIDTH-1; `w_sel` selects buffer 0..3.
  - On `we_i`=1 with `filled`<4, `data_i` is stored at `buf[w_sel][w_col]` and `w_col` increments.
  - At `w_col`=IMG_WIDTH-1: `w_col` returns to 0, `w_sel` advances modulo 4, `filled` increments, and `line_done_o` pulses on the next cycle.
- Write when full: `we_i`=1 with `filled`=4 is dropped, `overflow_o` sets and stays set until reset, and pointers do not move.
- Read side:
  - `r_col` counts 0..IMG_WIDTH-1; `r_sel` indexes the oldest held line.
  - Read is enabled when `filled`>=3.
  - On `rd_en_i`=1 while enabled, the next cycle presents `top_o`=`buf[r_sel][r_col]`, `mid_o`=`buf[r_sel+1][r_col]`, `bot_o`=`buf[r_sel+2][r_col]` (indices modulo 4) with `valid_o`=1. Latency is exactly 1 cycle.
  - `r_col` increments per accepted read.
- Read when not enabled: `rd_en_i`=1 with `filled`<3 is ignored; `valid_o`=0 next cycle and `r_col` is unchanged. Outputs hold their last values whenever `valid_o`=0.
- End of line read: the read at `r_col`=IMG_WIDTH-1 returns `r_col` to 0, advances `r_sel` modulo 4, decrements `filled`, and asserts `row_done_o` together with that column's `valid_o`.
- Simultaneous events: a write completing a line and a read completing a line in the same cycle leave `filled` unchanged; both pointers advance.
- Write/read same column: a write to a buffer never aliases a read, because reads only touch complete lines. A buffer freed by a row completion is writable from the next cycle.
- `window_ready_o` is registered: `filled`>=3, updated the cycle after the change to `filled`.
- `filled` is 3 bits wide, range 0..4, and never wraps.
- Back-to-back `rd_en_i` yields one column per cycle with no bubbles.
- `we_i` and `rd_en_i` are fully independent.

Test Plan:
- Reset check, IMG_WIDTH=10: hold `rst`=0 for 2 cycles with `we_i`=`rd_en_i`=1 -> every output 0; `window_ready_o` stays 0 after release until 30 pixels are written.
- Fill 3 lines, `data_i`=line*16+col for lines 0..2 -> `line_done_o` pulses 3 times; `window_ready_o`=1 one cycle after pixel 29.
- Stream `rd_en_i`=1 for 10 cycles -> `valid_o` high for 10 consecutive cycles starting 1 cycle later. Column 4 gives `top_o`=0x04, `mid_o`=0x14, `bot_o`=0x24. `row_done_o` is high with column 9 only; `window_ready_o` then drops.
- Read before ready: 2 lines written, pulse `rd_en_i` -> `valid_o` stays 0; a later read after line 3 returns column 0 (0x00/0x10/0x20).
- Overflow: write 41 pixels with no reads -> `overflow_o`=1 from pixel 41. A subsequent full line read followed by a write lands in buffer 0, verified by the next window (`bot_o`=new data).
- Simultaneous: with 3 lines held and line 4 at `w_col`=9, issue the final read and final write in the same cycle -> `filled` stays 3, `window_ready_o` stays 1, and the next window is lines 1/2/3.
